// File: rtl/noc_link_out_arbiter.sv
// noc_link_out_arbiter
//   Packet-atomic round-robin arbiter sharing one tile->NoC output channel
//   between INPUTS packet sources. A granted source owns the channel until the
//   handshake of its last flit, so packets are never interleaved. Arbitration
//   takes one bubble cycle in IDLE; while LOCKED the granted source is passed
//   straight through to the link with zero latency and no buffering.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_flit    : INPUTS*FLIT_WIDTH source flits, source i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   in_last    : per-source last-flit marker
//   in_valid   : per-source flit valid
//   in_ready   : per-source ready (only the granted source sees out_ready)
//   out_flit   : flit to the NoC link
//   out_last   : last flit of the packet
//   out_valid  : flit valid to the NoC
//   out_ready  : NoC ready
//   grant      : one-hot current owner, zero when idle
//   active     : high while a packet holds the channel
module noc_link_out_arbiter #(
  parameter int unsigned FLIT_WIDTH = 34,
  parameter int unsigned INPUTS     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]            in_last,
  input  logic [INPUTS-1:0]            in_valid,
  output logic [INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INPUTS-1:0]            grant,
  output logic                         active
);

  localparam int unsigned PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INPUTS-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  int unsigned        srch_idx;
  logic [PTR_W-1:0]   srch_idx_c;
  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   g_next;
  logic               locked;

  // Round-robin search: first valid source at or after ptr, wrapping.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    srch_idx   = 0;
    srch_idx_c = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      srch_idx = int'(ptr_q) + k;
      if (srch_idx >= INPUTS) begin
        srch_idx = srch_idx - INPUTS;
      end
      srch_idx_c = PTR_W'(srch_idx);
      if (!win_found && in_valid[srch_idx_c]) begin
        win_found = 1'b1;
        win_idx   = srch_idx_c;
      end
    end
  end

  // Index of the current owner and the pointer value that follows it.
  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (grant_q[i]) begin
        g_idx = PTR_W'(i);
      end
    end
    g_next = (g_idx == PTR_W'(INPUTS - 1)) ? '0 : g_idx + 1'b1;
  end

  // Outputs are decoded from state and forced idle while rst is high, so a
  // reset mid-packet blanks the link in the same cycle it is sampled.
  assign locked = (state_q == LOCKED) && !rst;

  always_comb begin
    out_flit  = '0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    in_ready  = '0;
    grant     = '0;
    active    = 1'b0;
    if (locked) begin
      for (int unsigned i = 0; i < INPUTS; i++) begin
        if (grant_q[i]) begin
          out_flit    = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
          out_last    = in_last[i];
          out_valid   = in_valid[i];
          in_ready[i] = out_ready;
        end
      end
      grant  = grant_q;
      active = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = LOCKED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      LOCKED: begin
        if (out_valid && out_ready && out_last) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = g_next;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_noc_link_out_arbiter.sv
// tb_noc_link_out_arbiter
//   Directed scenarios followed by a randomized run. A packet-level reference
//   model (current owner, round-robin pointer, per-source packet queues)
//   predicts every output each cycle; delivered flits are scoreboarded.
module tb_noc_link_out_arbiter;

  localparam int FW = 34;
  localparam int N  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*FW-1:0]   in_flit;
  logic [N-1:0]      in_last, in_valid, in_ready;
  logic [FW-1:0]     out_flit;
  logic              out_last, out_valid, out_ready;
  logic [N-1:0]      grant;
  logic              active;

  noc_link_out_arbiter #(.FLIT_WIDTH(FW), .INPUTS(N)) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp, n_err;

  // Reference model: owner = -1 when no packet holds the channel.
  int owner, rr;
  // Source behaviour
  bit            v[N];
  logic [FW-1:0] f[N];
  bit            l[N];
  int            rem[N], seq[N], pkt[N], stall[N];
  int            pq[N][$];
  bit            rnd_mode, ordy;
  // Observations and scoreboard
  int            hist[$];
  logic [FW-1:0] got[$], expq[$];
  int            dut_x, mdl_x;
  bit            prev_active;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_flit[i*FW +: FW] = f[i];
      in_valid[i]         = v[i];
      in_last[i]          = l[i];
    end
    out_ready = ordy;
  endtask

  task automatic check_outputs();
    logic [FW-1:0] ef;
    logic [N-1:0]  eg, er;
    logic          ev, el, ea;
    ef = '0; eg = '0; er = '0; ev = 1'b0; el = 1'b0; ea = 1'b0;
    if (!rst && owner >= 0) begin
      ef = f[owner]; ev = v[owner]; el = l[owner]; ea = 1'b1;
      eg[owner] = 1'b1;
      er[owner] = ordy;
    end
    chk("grant", grant, eg);
    chk("active", active, ea);
    chk("out_valid", out_valid, ev);
    chk("out_last", out_last, el);
    chk("out_flit", out_flit, ef);
    chk("in_ready", in_ready, er);
    if (out_valid && out_ready) begin
      dut_x++;
      got.push_back(out_flit);
    end
    if (active && !prev_active) begin
      for (int i = 0; i < N; i++) if (grant[i]) hist.push_back(i);
    end
    prev_active = active;
  endtask

  task automatic src_update(input int acc);
    for (int i = 0; i < N; i++) begin
      if (acc == i) begin
        rem[i]--;
        seq[i]++;
        v[i] = 1'b0;
        if (rem[i] == 0) pkt[i]++;
      end
      if (!v[i]) begin
        if (rem[i] == 0 && pq[i].size() > 0) begin
          rem[i] = pq[i].pop_front();
          seq[i] = 1;
        end
        if (rem[i] > 0) begin
          if (stall[i] > 0) stall[i]--;
          else if (rnd_mode && $urandom_range(3) == 0) ;
          else begin
            v[i] = 1'b1;
            f[i] = {2'(i), 16'(pkt[i]), 16'(seq[i])};
            l[i] = (rem[i] == 1);
          end
        end
      end
    end
  endtask

  task automatic step();
    int  acc;
    bit  found;
    drive();
    #3;
    check_outputs();
    acc = -1;
    if (!rst && owner >= 0 && v[owner] && ordy) acc = owner;
    @(posedge clk);
    if (rst) begin
      owner = -1;
      rr    = 0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && v[(rr + k) % N]) begin
          owner = (rr + k) % N;
          found = 1'b1;
        end
      end
    end else if (acc >= 0) begin
      mdl_x++;
      expq.push_back(f[owner]);
      if (l[owner]) begin
        rr    = (owner + 1) % N;
        owner = -1;
      end
    end
    src_update(acc);
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; rem[i] = 0; stall[i] = 0;
      pq[i].delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sources();
    hist.delete(); got.delete(); expq.delete();
    dut_x = 0; mdl_x = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic bit all_done();
    bit d;
    d = (owner < 0);
    for (int i = 0; i < N; i++) if (v[i] || rem[i] != 0 || pq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_idle(input string tag, input int max_cyc);
    int c;
    c = 0;
    while (!all_done() && c < max_cyc) begin
      step();
      c++;
    end
    if (!all_done()) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout: observed busy after %0d cycles expected idle", tag, c);
    end
  endtask

  task automatic chk_hist(input string tag, input int a, input int b, input int c, input int cnt);
    chk({tag, "_len"}, hist.size() >= cnt, 1);
    if (hist.size() >= 1 && cnt >= 1) chk({tag, "_g0"}, hist[0], a);
    if (hist.size() >= 2 && cnt >= 2) chk({tag, "_g1"}, hist[1], b);
    if (hist.size() >= 3 && cnt >= 3) chk({tag, "_g2"}, hist[2], c);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, dut_x, mdl_x);
    chk({tag, "_nflits"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) chk({tag, "_flit"}, got[i], expq[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    owner = -1; rr = 0; rnd_mode = 1'b0; ordy = 1'b1; prev_active = 1'b0;
    for (int i = 0; i < N; i++) begin
      f[i] = '0; seq[i] = 0; pkt[i] = 0;
    end
    rst = 1'b1;
    clear_sources();
    drive();

    // Reset state
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_active", active, 0);
    chk("rst_ptr", dut.ptr_q, 0);

    // Single requester: 3-flit packet from src1
    pq[1].push_back(3);
    src_update(-1);
    step();
    chk("sr_grant", grant, 3'b010);
    run_until_idle("sr", 10);
    step();
    chk("sr_active", active, 0);
    chk("sr_ptr", dut.ptr_q, 2);
    chk("sr_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("sr_f1", got[0], 34'h1_0000_0001);
      chk("sr_f2", got[1], 34'h1_0000_0002);
      chk("sr_f3", got[2], 34'h1_0000_0003);
    end

    // Round-robin: every source streams 2-flit packets
    do_reset();
    for (int i = 0; i < N; i++) begin
      pq[i].push_back(2);
      pq[i].push_back(2);
    end
    src_update(-1);
    repeat (18) step();
    chk("rr_xfers", dut_x, 12);
    chk_hist("rr", 0, 1, 2, 3);
    if (hist.size() >= 4) chk("rr_g3", hist[3], 0);
    chk("rr_done", all_done(), 1);
    chk_stream("rr");

    // Non-interleave: src0 stalls mid-packet while src2 waits
    do_reset();
    pq[0].push_back(3);
    pq[2].push_back(1);
    src_update(-1);
    stall[0] = 4;
    step();
    step();
    repeat (4) begin
      drive();
      #3;
      chk("ni_out_valid", out_valid, 0);
      chk("ni_ready2", in_ready[2], 0);
      #0;
      step_tail();
    end
    run_until_idle("ni", 20);
    chk_hist("ni", 0, 2, 0, 2);
    chk_stream("ni");

    // Backpressure during flit 2 of src1
    do_reset();
    pq[1].push_back(3);
    src_update(-1);
    step();
    step();
    ordy = 1'b0;
    repeat (5) step();
    ordy = 1'b1;
    run_until_idle("bp", 10);
    chk("bp_xfers", dut_x, 3);
    chk_stream("bp");

    // Single-flit packets from src0 and src2
    do_reset();
    pq[0].push_back(1);
    pq[2].push_back(1);
    src_update(-1);
    repeat (4) step();
    chk("sf_xfers", dut_x, 2);
    chk("sf_done", all_done(), 1);
    chk_hist("sf", 0, 2, 0, 2);
    chk("sf_ptr", dut.ptr_q, 0);

    // Reset in the middle of a 4-flit src2 packet
    do_reset();
    pq[2].push_back(4);
    src_update(-1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_sources();
    chk("rm_ptr", dut.ptr_q, 0);
    chk("rm_grant", grant, 0);
    chk("rm_valid", out_valid, 0);
    chk("rm_active", active, 0);
    step();
    hist.delete();
    pq[0].push_back(1);
    pq[2].push_back(2);
    src_update(-1);
    run_until_idle("rm", 20);
    chk_hist("rm", 0, 2, 0, 2);

    // Randomized traffic with backpressure and source stalls
    do_reset();
    rnd_mode = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && pq[i].size() == 0 && $urandom_range(7) == 0)
          pq[i].push_back(int'($urandom_range(4, 1)));
      end
      ordy = ($urandom_range(3) != 0);
      step();
    end
    ordy = 1'b1;
    rnd_mode = 1'b0;
    run_until_idle("rnd", 200);
    chk_stream("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Remainder of a step after outputs were already sampled by the caller.
  task automatic step_tail();
    int acc;
    check_outputs();
    acc = -1;
    if (!rst && owner >= 0 && v[owner] && ordy) acc = owner;
    @(posedge clk);
    if (owner >= 0 && acc >= 0) begin
      mdl_x++;
      expq.push_back(f[owner]);
      if (l[owner]) begin
        rr    = (owner + 1) % N;
        owner = -1;
      end
    end
    src_update(acc);
    #1;
  endtask

endmodule
